branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised fetch-stage branch predictor: direct-mapped BTB plus 2-bit saturating BHT.
//  Fetch looks it up with pc_f and gets a predicted direction and target.
//  The execute stage updates it when a branch or jump resolves.
//  Replaces the fixed predict-not-taken fetch policy of the 5-stage pipeline.
//  Supplies mispredict detection and statistics counters for the hazard unit and for debug.
// PARAMETERS
//  XLEN      32  address/data width
//  ENTRIES   16  BTB/BHT entries; power of two, >=2; IDX_W = $clog2(ENTRIES)
//  TAG_W     8   tag bits; tag = pc[TAG_W+IDX_W+1 : IDX_W+2]
//  MODE      1   0 = static not-taken (predict_taken_f tied 0, tables frozen); 1 = dynamic
//  CNT_W     16  width of the statistics counters
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      synchronous, active-high
//  pc_f             in   XLEN   fetch PC (word aligned)
//  predict_taken_f  out  1      predicted taken
//  predict_target_f out  XLEN   predicted target; 0 when no hit
//  upd_en_e         in   1      resolved branch/jump in E; must be 0 for flushed or bubble slots
//  upd_pc_e         in   XLEN   PC of the resolved instruction
//  upd_taken_e      in   1      actual outcome (pcsrc_e)
//  upd_is_jump_e    in   1      unconditional jump (jal/jalr)
//  upd_target_e     in   XLEN   actual target (pctarget_e)
//  upd_pred_taken_e in   1      prediction carried down the pipe with the instruction
//  upd_pred_tgt_e   in   XLEN   predicted target carried down the pipe
//  mispredict_e     out  1      combinational; redirect and flush required
//  branch_cnt       out  CNT_W  resolved updates seen, saturating
//  mispredict_cnt   out  CNT_W  mispredictions seen, saturating
// BEHAVIOUR
//  Entry contents: valid, tag[TAG_W], target[XLEN], ctr[2]. Index = pc[IDX_W+1:2].
//  Reset (sync, one cycle):
//   - every valid <= 0 and every ctr <= 2'b01
//   - branch_cnt and mispredict_cnt <= 0
//   - outputs are 0 in the cycle after reset
//   - reset wins over a simultaneous update
//  Lookup is combinational from registered tables:
//   - hit = valid & tag match
//   - predict_taken_f = MODE & hit & ctr[1]
//   - predict_target_f = hit ? target : 0
//  mispredict_e = upd_en_e & ((upd_pred_taken_e != upd_taken_e) |
//   (upd_taken_e & upd_pred_tgt_e != upd_target_e)).
//  Update at the clock edge when upd_en_e=1 and MODE=1:
//   - Hit, jump: ctr <= 2'b11; target <= upd_target_e.
//   - Hit, branch taken: ctr <= sat_inc(ctr) (11 stays 11); target <= upd_target_e.
//   - Hit, branch not taken: ctr <= sat_dec(ctr) (00 stays 00); target unchanged.
//   - Miss, taken: allocate/overwrite. valid <= 1, tag, target <= upd_target_e,
//     ctr <= 2'b11 for a jump, else 2'b10.
//   - Miss, not taken: no change (no allocation).
//  Aliasing: a different tag at the same index is a miss, so a taken update evicts the entry.
//  Same-cycle lookup and update of one index: lookup returns the OLD entry. There is no bypass.
//   The new contents are visible from the next cycle.
//  Statistics:
//   - branch_cnt += 1 on every upd_en_e (counted in MODE 0 as well)
//   - mispredict_cnt += 1 when mispredict_e
//   - both saturate at all-ones and never wrap
//  Latency: prediction is 0 cycles (same cycle as pc_f); training takes effect 1 cycle later.
//  Stall: the block has no enable. The pipeline holds pc_f stable, so the output stays stable.
// TESTING
//  1. Reset, then any pc_f -> predict_taken_f=0, predict_target_f=0, both counters 0.
//  2. Taken branch at 0x40 to 0x80 -> next cycle pc_f=0x40 gives taken=1, target=0x80;
//     mispredict_e was 1 and mispredict_cnt=1.
//  3. Train 0x40 taken x3, then not-taken x1 -> still predicts taken (ctr 11->10);
//     a second not-taken -> predicts not taken (ctr 01).
//  4. ENTRIES=16: taken at 0x40, then taken at 0x80 (same index, other tag) ->
//     0x40 misses, 0x80 hits.
//  5. Update and lookup of 0x40 in the same cycle -> lookup shows the pre-update value;
//     next cycle shows the new value.
//  6. MODE=0: 10 taken updates -> predict_taken_f stays 0, branch_cnt=10, mispredict_cnt=10.
//     Separately, preload mispredict_cnt to all-ones and issue one more mispredict ->
//     the count holds at all-ones.

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and execute update bundle for the branch predictor
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  pc_f;
    logic             predict_taken_f;
    logic [XLEN-1:0]  predict_target_f;
    logic             upd_en_e;
    logic [XLEN-1:0]  upd_pc_e;
    logic             upd_taken_e;
    logic             upd_is_jump_e;
    logic [XLEN-1:0]  upd_target_e;
    logic             upd_pred_taken_e;
    logic [XLEN-1:0]  upd_pred_tgt_e;
    logic             mispredict_e;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output pc_f, upd_en_e, upd_pc_e, upd_taken_e, upd_is_jump_e, upd_target_e,
               upd_pred_taken_e, upd_pred_tgt_e,
        input  predict_taken_f, predict_target_f, mispredict_e, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_f, upd_en_e, upd_pc_e, upd_taken_e, upd_is_jump_e, upd_target_e,
               upd_pred_taken_e, upd_pred_tgt_e,
        output predict_taken_f, predict_target_f, mispredict_e, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating BHT and mispredict statistics
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int MODE    = 1,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_mispredict;
    logic             w_unused_pc;

    assign w_f_idx = bp.pc_f[IDX_W+1:2];
    assign w_f_tag = bp.pc_f[TAG_W+IDX_W+1:IDX_W+2];
    assign w_u_idx = bp.upd_pc_e[IDX_W+1:2];
    assign w_u_tag = bp.upd_pc_e[TAG_W+IDX_W+1:IDX_W+2];
    assign w_unused_pc = ^{bp.pc_f[1:0], bp.pc_f[XLEN-1:TAG_W+IDX_W+2],
                           bp.upd_pc_e[1:0], bp.upd_pc_e[XLEN-1:TAG_W+IDX_W+2]};

    // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign bp.predict_taken_f  = (MODE != 0) && w_f_hit && r_ctr[w_f_idx][1];
    assign bp.predict_target_f = w_f_hit ? r_target[w_f_idx] : '0;

    assign w_mispredict = bp.upd_en_e &&
                          ((bp.upd_pred_taken_e != bp.upd_taken_e) ||
                           (bp.upd_taken_e && (bp.upd_pred_tgt_e != bp.upd_target_e)));
    assign bp.mispredict_e = w_mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if ((MODE != 0) && bp.upd_en_e) begin
            if (w_u_hit) begin
                if (bp.upd_is_jump_e) begin
                    r_ctr[w_u_idx]    <= 2'b11;
                    r_target[w_u_idx] <= bp.upd_target_e;
                end else if (bp.upd_taken_e) begin
                    r_ctr[w_u_idx]    <= (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : r_ctr[w_u_idx] + 2'd1;
                    r_target[w_u_idx] <= bp.upd_target_e;
                end else begin
                    r_ctr[w_u_idx]    <= (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : r_ctr[w_u_idx] - 2'd1;
                end
            end else if (bp.upd_taken_e) begin
                // A miss on a taken outcome evicts whatever alias occupied the slot.
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= bp.upd_target_e;
                r_ctr[w_u_idx]    <= bp.upd_is_jump_e ? 2'b11 : 2'b10;
            end
        end
    end

    // Statistics run in both modes and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (bp.upd_en_e && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispredict && !(&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign bp.branch_cnt     = r_branch_cnt;
    assign bp.mispredict_cnt = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor against a table model
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .CNT_W(16)) bp0();
    branch_predictor_if #(.XLEN(32), .CNT_W(4))  bp1();

    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .MODE(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bp(bp0.slave));
    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .MODE(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .bp(bp1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid  [16];
    int          m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int          m_bcnt0, m_mcnt0, m_bcnt1, m_mcnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int m_tg(input logic [31:0] pc);
        return int'((pc / 64) % 256);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_target[m_idx(pc)] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bcnt0 = 0; m_mcnt0 = 0; m_bcnt1 = 0; m_mcnt1 = 0;
    endtask

    task automatic step(input logic [31:0] pc, input bit en, input logic [31:0] upc,
                        input bit tk, input bit jp, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt);
        bit mp;
        int i;
        @(negedge clk);
        bp0.pc_f = pc; bp0.upd_en_e = en; bp0.upd_pc_e = upc; bp0.upd_taken_e = tk;
        bp0.upd_is_jump_e = jp; bp0.upd_target_e = tgt;
        bp0.upd_pred_taken_e = ptk; bp0.upd_pred_tgt_e = ptgt;
        bp1.pc_f = pc; bp1.upd_en_e = en; bp1.upd_pc_e = upc; bp1.upd_taken_e = tk;
        bp1.upd_is_jump_e = jp; bp1.upd_target_e = tgt;
        bp1.upd_pred_taken_e = ptk; bp1.upd_pred_tgt_e = ptgt;
        #1;
        mp = en && ((ptk != tk) || (tk && (ptgt != tgt)));
        check("pred_taken", bp0.predict_taken_f, m_ptaken(pc));
        check("pred_target", bp0.predict_target_f, m_ptgt(pc));
        check("m0_pred_taken", bp1.predict_taken_f, 0);
        check("m0_pred_target", bp1.predict_target_f, 0);
        check("mispredict", bp0.mispredict_e, mp);
        check("m0_mispredict", bp1.mispredict_e, mp);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (en) begin
            if (m_bcnt0 < 65535) m_bcnt0++;
            if (m_bcnt1 < 15) m_bcnt1++;
            if (mp && m_mcnt0 < 65535) m_mcnt0++;
            if (mp && m_mcnt1 < 15) m_mcnt1++;
            i = m_idx(upc);
            if (m_hit(upc)) begin
                if (jp) begin
                    m_ctr[i] = 3; m_target[i] = tgt;
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_target[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = m_tg(upc); m_target[i] = tgt;
                m_ctr[i] = jp ? 3 : 2;
            end
        end
        #1;
        check("branch_cnt", bp0.branch_cnt, m_bcnt0);
        check("mispredict_cnt", bp0.mispredict_cnt, m_mcnt0);
        check("m0_branch_cnt", bp1.branch_cnt, m_bcnt1);
        check("m0_mispredict_cnt", bp1.mispredict_cnt, m_mcnt1);
    endtask

    task automatic idle(input logic [31:0] pc);
        step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pc, upc, tgt, ptgt;
        bit tk, jp, ptk;

        reset = 1'b1;
        bp0.pc_f = '0; bp0.upd_en_e = 0; bp0.upd_pc_e = '0; bp0.upd_taken_e = 0;
        bp0.upd_is_jump_e = 0; bp0.upd_target_e = '0; bp0.upd_pred_taken_e = 0; bp0.upd_pred_tgt_e = '0;
        bp1.pc_f = '0; bp1.upd_en_e = 0; bp1.upd_pc_e = '0; bp1.upd_taken_e = 0;
        bp1.upd_is_jump_e = 0; bp1.upd_target_e = '0; bp1.upd_pred_taken_e = 0; bp1.upd_pred_tgt_e = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        idle($urandom & 32'hFFFF_FFFC);
        check("rst_taken", bp0.predict_taken_f, 0);
        check("rst_target", bp0.predict_target_f, 0);
        check("rst_bcnt", bp0.branch_cnt, 0);
        check("rst_mcnt", bp0.mispredict_cnt, 0);

        step(32'h0, 1, 32'h40, 1, 0, 32'h80, 0, 32'h0);
        check("t2_mcnt", bp0.mispredict_cnt, 1);
        idle(32'h40);
        check("t2_taken", bp0.predict_taken_f, 1);
        check("t2_target", bp0.predict_target_f, 32'h80);

        repeat (2) step(32'h40, 1, 32'h40, 1, 0, 32'h80, 1, 32'h80);
        step(32'h40, 1, 32'h40, 0, 0, 32'h44, 1, 32'h80);
        check("t3_one_nt", bp0.predict_taken_f, 1);
        step(32'h40, 1, 32'h40, 0, 0, 32'h44, 1, 32'h80);
        check("t3_two_nt", bp0.predict_taken_f, 0);

        step(32'h40, 1, 32'h40, 1, 0, 32'h90, 0, 32'h0);
        step(32'h40, 1, 32'h80, 1, 0, 32'hA0, 0, 32'h0);
        check("t4_evict_old", bp0.predict_target_f, 32'h0);
        idle(32'h80);
        check("t4_new_hit", bp0.predict_target_f, 32'hA0);

        step(32'h80, 1, 32'h80, 0, 0, 32'h84, 1, 32'hA0);
        check("t5_after", bp0.predict_taken_f, 0);

        reset = 1'b1;
        step(32'h80, 1, 32'h80, 1, 1, 32'hC0, 0, 32'h0);
        reset = 1'b0;
        check("rst_win_bcnt", bp0.branch_cnt, 0);
        check("rst_win_target", bp0.predict_target_f, 0);

        for (int k = 0; k < 10; k++) step(32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 32'h0);
        check("t6_m0_bcnt", bp1.branch_cnt, 10);
        check("t6_m0_mcnt", bp1.mispredict_cnt, 10);
        for (int k = 0; k < 10; k++) step(32'h100, 1, 32'h104, 1, 0, 32'h300, 0, 32'h0);
        check("t6_m0_sat", bp1.mispredict_cnt, 4'hF);

        for (int k = 0; k < 400; k++) begin
            pc  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 6);
            upc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 6);
            jp  = ($urandom_range(0, 4) == 0);
            tk  = jp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 1) == 1) begin
                ptk = m_ptaken(upc); ptgt = m_ptgt(upc);
            end else begin
                ptk = 1'($urandom_range(0, 1)); ptgt = $urandom & 32'h0000_0FFC;
            end
            step(pc, 1'($urandom_range(0, 3) != 0), upc, tk, jp, tgt, ptk, ptgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
